// File: rtl/gsquare_regen_if.sv
// Stream bundle for the unary squarer: advance/restart controls, random word, input bit and result.
// The squarer is the slave; whatever drives the stream and consumes the result is the master.
// There is no ready path: the result is registered and valid for one cycle only, so a consumer must take it as it appears.
interface gsquare_regen_if #(
  parameter int DEP = 5
);
  logic           en;        // stream-advance qualifier
  logic           clr;       // synchronous restart
  logic [DEP-1:0] randNum;   // random word, uncorrelated with in
  logic           in;        // live unary input bit
  logic           out;       // squared unary bit
  logic           outValid;  // out is meaningful this cycle

  modport master (
    output en,
    output clr,
    output randNum,
    output in,
    input  out,
    input  outValid
  );

  modport slave (
    input  en,
    input  clr,
    input  randNum,
    input  in,
    output out,
    output outValid
  );
endinterface

// File: rtl/gsquare_regen.sv
// Unary squarer: tracks P(in) in a saturating counter, regenerates a decorrelated copy and multiplies it with in.
// Latency: one cycle from in to out; outValid appears only after 2**DEP enabled warm-up cycles.
// No backpressure: en=0 freezes all state and drives outValid low on the following cycle.
// Optional build macro GSQUARE_BIPOLAR_EN selects bipolar coding (XNOR multiply); the default is unipolar (AND).
module gsquare_regen #(
  parameter int DEP = 5
) (
  input  logic            clk,
  input  logic            rst,
  gsquare_regen_if.slave  bus
);

  // Counter midpoint (estimate of p = 0.5), saturation limits and last warm-up count.
  localparam logic [DEP-1:0] CNT_MID   = {1'b1, {(DEP-1){1'b0}}};
  localparam logic [DEP-1:0] CNT_MAX   = {DEP{1'b1}};
  localparam logic [DEP-1:0] CNT_MIN   = {DEP{1'b0}};
  localparam logic [DEP-1:0] WCNT_LAST = {DEP{1'b1}};

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [DEP-1:0] cnt_q,   cnt_d;
  logic [DEP-1:0] wcnt_q,  wcnt_d;
  logic           out_q,   out_d;
  logic           out_valid_q, out_valid_d;

  logic regen;
  logic cnt_inc;
  logic cnt_dec;
  logic prod;

  // Regenerated bit: a fresh Bernoulli draw with the counter's current estimate of P(in).
  always_comb begin
    regen   = (cnt_q > bus.randNum);
    cnt_inc = bus.in & ~regen & (cnt_q != CNT_MAX);
    cnt_dec = ~bus.in & regen & (cnt_q != CNT_MIN);
`ifdef GSQUARE_BIPOLAR_EN
    prod    = ~(bus.in ^ regen);
`else
    prod    = bus.in & regen;
`endif
  end

  // Tracking counter: nudges toward P(in) and saturates at both ends; restart returns it to mid-scale.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = CNT_MID;
    end else if (bus.en) begin
      if (cnt_inc) begin
        cnt_d = cnt_q + 1'b1;
      end else if (cnt_dec) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Warm-up sequencer: counts 2**DEP enabled cycles in WARM, then stays in RUN until restart.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (bus.clr) begin
      state_d = WARM;
      wcnt_d  = '0;
    end else if (bus.en) begin
      case (state_q)
        WARM: begin
          if (wcnt_q == WCNT_LAST) begin
            state_d = RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WARM;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // Output stage: product is only meaningful once the estimate has settled and the stream advances.
  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    if ((state_q == RUN) && bus.en && !bus.clr) begin
      out_d       = prod;
      out_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the warm-up starting point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WARM;
      cnt_q       <= CNT_MID;
      wcnt_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.outValid = out_valid_q;

  // Counter never wraps from the top end to the bottom end or back.
  a_no_wrap_high: assert property (@(posedge clk) disable iff (rst)
    (cnt_q == CNT_MAX) |=> (cnt_q != CNT_MIN));
  a_no_wrap_low: assert property (@(posedge clk) disable iff (rst)
    (cnt_q == CNT_MIN) |=> (cnt_q != CNT_MAX));

  // A valid result is only ever produced from RUN.
  a_valid_from_run: assert property (@(posedge clk) disable iff (rst)
    out_valid_d |-> (state_q == RUN));

  // Frozen stream leaves the estimate and sequencer untouched.
  a_freeze: assert property (@(posedge clk) disable iff (rst)
    (!bus.en && !bus.clr) |=> ($stable(cnt_q) && $stable(wcnt_q) && $stable(state_q)));

endmodule
